data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to data_ok; legal range is 1..15.
REQ-002 The block SHALL have parameter AW, default 8, giving the word-index width (memory depth 2^AW words of 32 bits).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: asynchronous active-low reset (0 = reset asserted).
REQ-006 Port req, input, 1: requester has a valid request.
REQ-007 Port wr, input, 1: 1 = write, 0 = read.
REQ-008 Port size, input, 2: 0 = byte, 1 = halfword, 2 = word, 3 = treated as word.
REQ-009 Port addr, input, 32: byte address.
REQ-010 Port wdata, input, 32: write data, already lane-aligned by the requester.
REQ-011 Port addr_ok, output, 1: request accepted this cycle when req is also 1.
REQ-012 Port data_ok, output, 1: one-cycle response pulse.
REQ-013 Port rdata, output, 32: full read word, valid when data_ok is 1.
REQ-014 Port misalign, output, 1: accepted request was misaligned, valid with data_ok.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 addr_ok SHALL equal (state==IDLE) AND rst; it SHALL be combinational, with no dependence on req.
REQ-017 A handshake SHALL occur on a rising edge where req=1 and addr_ok=1; wr, size, addr and wdata SHALL be latched on that edge.
REQ-018 On handshake with LATENCY=1 the next state SHALL be RESP; otherwise it SHALL be WAIT with counter=LATENCY-2.
REQ-019 In WAIT the counter SHALL decrement each cycle; at counter=0 the next state SHALL be RESP.
REQ-020 In RESP data_ok SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-021 A handshake at edge T SHALL produce data_ok high in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
REQ-022 At most one transaction SHALL be outstanding; req while not IDLE SHALL be ignored, with no queuing.
REQ-023 Misalignment SHALL be defined as size=1 with addr[0]=1, or size in {2,3} with addr[1:0]!=0.
REQ-024 The memory word index SHALL be addr[AW+1:2]; upper address bits SHALL be ignored, so addresses alias modulo 2^(AW+2).
REQ-025 Writes SHALL be committed on the edge ending the RESP cycle, and only if aligned.
REQ-026 Write byte enables SHALL be:
- byte: lane addr[1:0]
- half: lanes {addr[1],0} and {addr[1],1}
- word: all four lanes
REQ-027 Written bytes SHALL be taken from the same lanes of wdata; other lanes SHALL be unchanged.
REQ-028 For an aligned read, rdata SHALL be the full stored word at the index, reflecting all writes committed before the RESP cycle.
REQ-029 For a write response, rdata SHALL be 0.
REQ-030 For a misaligned access, rdata SHALL be 0, no memory change SHALL occur, misalign=1 with data_ok, and latency SHALL be unchanged.
REQ-031 Outside RESP, data_ok, misalign and rdata SHALL all be 0.
REQ-032 A new request SHALL be accepted in the IDLE cycle immediately after RESP; back-to-back throughput is one transaction per LATENCY+1 cycles.

Reset
REQ-033 While rst=0, the block SHALL hold state=IDLE, counter=0, addr_ok=0, data_ok=0, rdata=0 and misalign=0.
REQ-034 On rst deassertion, addr_ok SHALL rise in the same cycle.
REQ-035 Reset asserted in WAIT or RESP SHALL abandon the transaction: no write commit and no data_ok pulse.
REQ-036 Memory contents SHALL NOT be reset; a read of an address never written returns an unspecified value.

Verification
REQ-037 Word write then read, LATENCY=2: write addr 0x10, data 0xDEADBEEF -> data_ok 2 cycles after accept with rdata 0; read 0x10 -> data_ok 2 cycles after accept with rdata 0xDEADBEEF and misalign 0.
REQ-038 Byte and half merge: word 0x11223344 at 0x20, then byte write 0x000000AA at 0x20, then half write 0x55660000 at 0x22 -> read 0x20 returns 0x556633AA.
REQ-039 Misaligned access: word write 0xFFFFFFFF at 0x21 -> data_ok with misalign 1; a subsequent read of 0x20 still returns the prior contents.
REQ-040 Busy and back-to-back, LATENCY=1: req held high continuously for reads of 0x10 then 0x20 -> addr_ok and data_ok alternate each cycle; two responses arrive in 4 cycles; req during RESP is not accepted.
REQ-041 Reset mid-operation: write 0x12345678 to 0x30 with rst pulsed low during WAIT -> no data_ok; after reset, addr_ok=1 immediately and a read of 0x30 does not return 0x12345678 (the location is pre-loaded with 0 beforehand).
REQ-042 Aliasing, AW=8: word write 0xCAFEF00D at 0x000 then read 0x400 -> rdata 0xCAFEF00D.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: single-outstanding SRAM responder with fixed latency, byte-lane writes and misalignment flagging
module data_sram_resp #(
    parameter int LATENCY = 2,
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic wr_q, mis_q;
    logic [1:0] size_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [2**AW];
    logic hs, mis_in, unused_addr;
    logic [3:0] be;
    assign hs = req & addr_ok;
    assign mis_in = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'd0);
    assign unused_addr = ^addr[31:AW+2];
    assign be = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // state and wait counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end
    // next-state logic: count down the remaining latency in WAIT
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: if (hs) begin
                state_nxt = LATENCY == 1 ? RESP : WAIT;
                cnt_nxt = CNT_INIT;
            end
            WAIT: if (cnt == 4'd0) state_nxt = RESP; else cnt_nxt = cnt - 4'd1;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // capture the request on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= 1'b0;
            mis_q <= 1'b0;
            size_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
        end else if (hs) begin
            wr_q <= wr;
            mis_q <= mis_in;
            size_q <= size;
            addr_q <= addr[AW+1:0];
            wdata_q <= wdata;
        end
    end
    // outputs: only RESP drives response data
    always_comb begin
        addr_ok = state == IDLE && rst;
        data_ok = state == RESP;
        misalign = data_ok && mis_q;
        rdata = (data_ok && !wr_q && !mis_q) ? mem[addr_q[AW+1:2]] : '0;
    end
    // aligned writes commit on the edge ending RESP; reset forces IDLE so abandoned writes never land
    always_ff @(posedge clk) begin
        if (state == RESP && wr_q && !mis_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed table and corner-sequence checks for data_sram_resp
module tb_data_sram_resp;
    logic clk = 1'b0, rst = 1'b0;
    logic req = 1'b0, wr = 1'b0;
    logic [1:0] size = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic addr_ok, data_ok, misalign;
    logic [31:0] rdata;
    logic b_req = 1'b0, b_wr = 1'b0;
    logic [1:0] b_size = 2'd2;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic b_addr_ok, b_data_ok, b_misalign;
    logic [31:0] b_rdata;
    int tests = 0, fails = 0;

    typedef struct {
        logic w;
        logic [1:0] s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic exp_mis;
    } vec_t;
    vec_t vt[16];

    always #5 clk = ~clk;

    data_sram_resp #(.LATENCY(2), .AW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .misalign(misalign));

    data_sram_resp #(.LATENCY(1), .AW(8)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .wr(b_wr), .size(b_size), .addr(b_addr), .wdata(b_wdata),
        .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata), .misalign(b_misalign));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic mis, output int lat);
        @(negedge clk);
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        chk("addr_ok_idle", {31'd0, addr_ok}, 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        rd = '0; mis = 1'b0; lat = 0;
        while (lat <= 20) begin
            @(negedge clk);
            lat++;
            if (data_ok) begin
                rd = rdata;
                mis = misalign;
                break;
            end
        end
        @(negedge clk);
        chk("data_ok_pulse_end", {31'd0, data_ok}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic mis;
        int lat;
        logic seen;
        logic [7:0] ok_exp = 8'b10101010;
        logic [31:0] rde[8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'h0, 32'h22222222, 32'h0};

        vt[0]  = '{1'b1, 2'd2, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 2'd2, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 2'd2, 32'h020, 32'h11223344, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 2'd0, 32'h020, 32'h000000AA, 32'h0,        1'b0};
        vt[4]  = '{1'b1, 2'd1, 32'h022, 32'h55660000, 32'h0,        1'b0};
        vt[5]  = '{1'b0, 2'd2, 32'h020, 32'h0,        32'h556633AA, 1'b0};
        vt[6]  = '{1'b1, 2'd2, 32'h021, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[7]  = '{1'b0, 2'd2, 32'h020, 32'h0,        32'h556633AA, 1'b0};
        vt[8]  = '{1'b0, 2'd1, 32'h021, 32'h0,        32'h0,        1'b1};
        vt[9]  = '{1'b1, 2'd2, 32'h000, 32'hCAFEF00D, 32'h0,        1'b0};
        vt[10] = '{1'b0, 2'd2, 32'h400, 32'h0,        32'hCAFEF00D, 1'b0};
        vt[11] = '{1'b0, 2'd0, 32'h023, 32'h0,        32'h556633AA, 1'b0};
        vt[12] = '{1'b1, 2'd3, 32'h040, 32'h01020304, 32'h0,        1'b0};
        vt[13] = '{1'b1, 2'd0, 32'h043, 32'hAB000000, 32'h0,        1'b0};
        vt[14] = '{1'b1, 2'd1, 32'h041, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[15] = '{1'b0, 2'd3, 32'h040, 32'h0,        32'hAB020304, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
        chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_b_addr_ok", {31'd0, b_addr_ok}, 32'd0);
        #2 rst = 1'b1;
        #1 chk("rst_release_addr_ok", {31'd0, addr_ok}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            txn(vt[i].w, vt[i].s, vt[i].a, vt[i].d, rd, mis, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_misalign", i), {31'd0, mis}, {31'd0, vt[i].exp_mis});
            chk($sformatf("vec%0d_latency", i), lat, 32'd2);
        end

        txn(1'b1, 2'd2, 32'h30, 32'h0, rd, mis, lat);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'h12345678;
        @(posedge clk);
        #1 req = 1'b0;
        rst = 1'b0;
        #1 chk("midrst_addr_ok", {31'd0, addr_ok}, 32'd0);
        @(negedge clk);
        chk("midrst_data_ok", {31'd0, data_ok}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_release_addr_ok", {31'd0, addr_ok}, 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= data_ok;
        end
        chk("midrst_no_data_ok", {31'd0, seen}, 32'd0);
        txn(1'b0, 2'd2, 32'h30, 32'h0, rd, mis, lat);
        chk("midrst_read_0x30", rd, 32'h0);
        chk("midrst_read_latency", lat, 32'd2);

        @(negedge clk);
        b_req = 1'b1; b_wr = 1'b1; b_size = 2'd2; b_addr = 32'h10; b_wdata = 32'h11111111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_addr_ok", k), {31'd0, b_addr_ok}, {31'd0, ok_exp[k]});
            chk($sformatf("b2b%0d_data_ok", k), {31'd0, b_data_ok}, {31'd0, ~ok_exp[k]});
            chk($sformatf("b2b%0d_rdata", k), b_rdata, rde[k]);
            if (k == 0) begin b_addr = 32'h20; b_wdata = 32'h22222222; end
            if (k == 2) begin b_wr = 1'b0; b_addr = 32'h10; end
            if (k == 4) b_addr = 32'h20;
            if (k == 6) b_req = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
